// File: rtl/dev_bus_arbiter.sv
// Two-master (M0 = CPU, M1 = DMA) arbiter for the peripheral bridge port: registered grant FSM,
// round-robin tie-break, optional per-tenure beat limit enabled by ARB_HOLD_LIMIT_EN.
module dev_bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWe,
  output logic [3:0]  BE,
  input  logic [31:0] PrRD,
  output logic [1:0]  dbg_state
);

  // Encoding matches {m1_gnt, m0_gnt} so the debug state reads directly as the grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // 1: M1 was the most recent owner
  logic   hold_expired;
  logic   cfg_ok;

  assign cfg_ok = (HOLD_MAX >= 1) && (HOLD_MAX < (1 << CNT_W));

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = (hold_cnt_q >= HOLD_LAST);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if ((m0_ack || m1_ack) && (hold_cnt_q < HOLD_SAT)) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  assign m0_gnt    = (state_q == OWN0);
  assign m1_gnt    = (state_q == OWN1);
  assign m0_ack    = m0_gnt & m0_req;
  assign m1_ack    = m1_gnt & m1_req;
  assign m0_rd     = m0_ack ? PrRD : 32'h0;
  assign m1_rd     = m1_ack ? PrRD : 32'h0;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req && !m1_req)      state_d = OWN0;
        else if (m1_req && !m0_req) state_d = OWN1;
        else if (m0_req && m1_req)  state_d = last_q ? OWN0 : OWN1;
      end
      OWN0: begin
        if (m0_req) begin
          if (m1_req && hold_expired) state_d = OWN1;
        end else begin
          state_d = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          if (m0_req && hold_expired) state_d = OWN0;
        end else begin
          state_d = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Only a real owner leaving updates the round-robin pointer; IDLE -> OWNx keeps it.
    if ((state_d != state_q) && (state_q != IDLE)) begin
      last_d = (state_q == OWN1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // PrWe follows ack, so a granted owner that has dropped req can never write.
  always_comb begin
    PrAddr = 30'h0;
    PrWD   = 32'h0;
    PrWe   = 1'b0;
    BE     = 4'h0;
    if (m0_ack) begin
      PrAddr = m0_addr;
      PrWD   = m0_wd;
      PrWe   = m0_we;
      BE     = m0_be;
    end else if (m1_ack) begin
      PrAddr = m1_addr;
      PrWD   = m1_wd;
      PrWe   = m1_we;
      BE     = m1_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(m0_gnt && m1_gnt));
      assert (cfg_ok);
    end
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Scenario bench for dev_bus_arbiter: inputs change 1 time unit after posedge (as a master would),
// outputs are sampled on the negedge and compared against a queue of expected bus snapshots.
module tb_dev_bus_arbiter;
  localparam int W = 137;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [29:0] m0_addr = 30'h1FC0, m1_addr = 30'h0ABC;
  logic [31:0] m0_wd = 32'h5A, m1_wd = 32'h1234_5678;
  logic        m0_we = 1'b1, m1_we = 1'b1;
  logic [3:0]  m0_be = 4'hF, m1_be = 4'h3;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWe;
  logic [3:0]  BE;
  logic [31:0] PrRD = 32'hDEAD_BEEF;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, exp_v;
  int pass_cnt = 0;
  int chk_cnt  = 0;

  dev_bus_arbiter #(.HOLD_MAX(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe), .BE(BE), .PrRD(PrRD),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  assign obs = {m1_gnt, m0_gnt, dbg_state, m0_ack, m1_ack, PrWe, BE, PrAddr, PrWD, m0_rd, m1_rd};

  // Expected snapshot for a cycle where the grant is (g0,g1) and the masters drive req (r0,r1).
  function automatic logic [W-1:0] mk_exp(input bit g0, input bit g1, input bit r0, input bit r1);
    logic a0, a1, we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wd, rd0, rd1;
    a0 = g0 & r0;
    a1 = g1 & r1;
    we = 1'b0; be = 4'h0; addr = 30'h0; wd = 32'h0;
    if (a0) begin we = m0_we; be = m0_be; addr = m0_addr; wd = m0_wd; end
    if (a1) begin we = m1_we; be = m1_be; addr = m1_addr; wd = m1_wd; end
    rd0 = a0 ? PrRD : 32'h0;
    rd1 = a1 ? PrRD : 32'h0;
    return {g1, g0, g1, g0, a0, a1, we, be, addr, wd, rd0, rd1};
  endfunction

  // Driver tasks
  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit [0:4] rs = 5'b00111;
    bit [0:4] g0 = 5'b00011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rst_n = rs[i[2:0]]; m0_req = 1'b1; m1_req = 1'b1;
      exp_q.push_back(mk_exp(g0[i[2:0]], 1'b0, 1'b1, 1'b1));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL reset cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_write();
    bit [0:3] r0 = 4'b1100;
    bit [0:3] g0 = 4'b0110;
    apply_reset();
    m0_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      m0_req = r0[i[1:0]]; m1_req = 1'b0;
      exp_q.push_back(mk_exp(g0[i[1:0]], 1'b0, r0[i[1:0]], 1'b0));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL single_write cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_tie();
    bit [0:9] r0 = 10'b1100001100;
    bit [0:9] r1 = 10'b1111101100;
    bit [0:9] g0 = 10'b0110000110;
    bit [0:9] g1 = 10'b0001110000;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      m0_req = r0[i[3:0]]; m1_req = r1[i[3:0]];
      exp_q.push_back(mk_exp(g0[i[3:0]], g1[i[3:0]], r0[i[3:0]], r1[i[3:0]]));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL tie cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // Both masters request continuously: tenures of 4 beats alternate when the limit is enabled.
  task automatic test_hold_limit();
    bit g0, g1;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      m0_req = 1'b1; m1_req = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      g0 = (i != 0) && (((i - 1) / 4) % 2 == 0);
      g1 = (i != 0) && (((i - 1) / 4) % 2 == 1);
`else
      g0 = (i != 0);
      g1 = 1'b0;
`endif
      exp_q.push_back(mk_exp(g0, g1, 1'b1, 1'b1));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL hold_limit cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  // M0 alone long enough to saturate its counter, then M1 arrives and must win at the next edge.
  task automatic test_hold_saturate();
    bit g0, g1, r1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      r1 = (i >= 6);
      m0_req = 1'b1; m1_req = r1;
`ifdef ARB_HOLD_LIMIT_EN
      g0 = (i >= 1) && (i <= 6);
      g1 = (i >= 7);
`else
      g0 = (i >= 1);
      g1 = 1'b0;
`endif
      exp_q.push_back(mk_exp(g0, g1, 1'b1, r1));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL hold_saturate cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_read();
    bit [0:3] r1 = 4'b1100;
    bit [0:3] g1 = 4'b0110;
    apply_reset();
    m1_we = 1'b0;
    PrRD  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = r1[i[1:0]];
      exp_q.push_back(mk_exp(1'b0, g1[i[1:0]], 1'b0, r1[i[1:0]]));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL read cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    bit [0:4] rs = 5'b10011;
    bit [0:4] g1 = 5'b01001;
    apply_reset();
    m1_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rst_n = rs[i[2:0]]; m0_req = 1'b0; m1_req = 1'b1;
      exp_q.push_back(mk_exp(1'b0, g1[i[2:0]], 1'b0, 1'b1));
      @(negedge clk);
      exp_v = exp_q.pop_front(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL mid_reset cyc %0d: got %h want %h", i, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_hold_limit();
    test_hold_saturate();
    test_read();
    test_mid_reset();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
